// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// Fair round-robin grant, registered RAM command, and a two-stage read
// tag pipeline that routes returning read data to the requester that
// issued the read.
//
// state  | meaning
// IDLE   | no command issued this cycle, ram_we forced low
// CMD_A  | registered RAM command belongs to requester A
// CMD_B  | registered RAM command belongs to requester B
module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          we_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_a,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, CMD_A, CMD_B} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_b;   // 1 = B won the most recent handshake
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_t1_v;
  logic          r_t1_b;
  logic          r_t2_v;
  logic          r_t2_b;
  logic [DW-1:0] r_rdata;

  logic          w_hs_a;
  logic          w_hs_b;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_cmd_rd;

  // Grant favours the requester that did not win last; nothing granted in reset.
  assign gnt_a  = ~rst & req_a & (~req_b | r_last_b);
  assign gnt_b  = ~rst & req_b & (~req_a | ~r_last_b);
  assign w_hs_a = req_a & gnt_a;
  assign w_hs_b = req_b & gnt_b;

  // Next state and the command mux for the winning requester.
  always_comb begin
    w_state_nxt = IDLE;
    w_we        = 1'b0;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    if (w_hs_a) begin
      w_state_nxt = CMD_A;
      w_we        = we_a;
      w_addr      = addr_a;
      w_wdata     = wdata_a;
    end else if (w_hs_b) begin
      w_state_nxt = CMD_B;
      w_we        = we_b;
      w_addr      = addr_b;
      w_wdata     = wdata_b;
    end
  end

  // State register, last-winner pointer and registered RAM command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last_b <= 1'b1;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      if (w_hs_a)      r_last_b <= 1'b0;
      else if (w_hs_b) r_last_b <= 1'b1;
    end
  end

  // A write strobe only exists while a command is owned; IDLE keeps it low.
  assign ram_we    = (r_state != IDLE) & r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign w_cmd_rd  = (r_state != IDLE) & ~r_we;

  // Read tags follow the command register by the RAM's two-edge latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t1_v <= 1'b0;
      r_t1_b <= 1'b0;
      r_t2_v <= 1'b0;
      r_t2_b <= 1'b0;
    end else begin
      r_t1_v <= w_cmd_rd;
      r_t1_b <= (r_state == CMD_B);
      r_t2_v <= r_t1_v;
      r_t2_b <= r_t1_b;
    end
  end

  assign rvalid_a = r_t2_v & ~r_t2_b;
  assign rvalid_b = r_t2_v & r_t2_b;

  // Hold the most recent returned word so rdata is stable between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_rdata <= '0;
    else if (r_t2_v) r_rdata <= ram_rdata;
  end

  assign rdata = r_t2_v ? ram_rdata : r_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed stimulus with a behavioural RAM,
// read-return checking through an expected-response queue.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  typedef struct {
    logic       own_b;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] ram_aq;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Single-port RAM: address sampled one edge after the command, data out the edge after.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_aq    <= ram_addr;
    ram_rdata <= mem[ram_aq];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic own_b, input logic [7:0] data);
    exp_t e;
    e.own_b = own_b;
    e.data  = data;
    sb.push_back(e);
  endtask

  // Monitor: every read return must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rvalid_a || rvalid_b) begin
      chk("rvalid_exclusive", {31'd0, rvalid_a & rvalid_b}, 32'd0);
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_rvalid: got rvalid_a=%0b rvalid_b=%0b expected none at %0t",
                 rvalid_a, rvalid_b, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_owner_b", {31'd0, rvalid_b}, {31'd0, e.own_b});
        chk("rd_data", {24'd0, rdata}, {24'd0, e.data});
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

    // Reset state, with both requesting: no grants.
    tick(); tick();
    chk("rst_gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("rst_gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    req_a = 1'b0; req_b = 1'b0;
    rst = 1'b0;
    tick();

    // A writes 8'h56 to 55.
    req_a = 1'b1; we_a = 1'b1; addr_a = 10'd55; wdata_a = 8'h56;
    #1;
    chk("wr_gnt_a", {31'd0, gnt_a}, 32'd1);
    chk("wr_gnt_b", {31'd0, gnt_b}, 32'd0);
    tick();
    req_a = 1'b0;
    chk("wr_ram_we", {31'd0, ram_we}, 32'd1);
    chk("wr_ram_addr", {22'd0, ram_addr}, 32'd55);
    chk("wr_ram_wdata", {24'd0, ram_wdata}, 32'h56);
    tick();
    chk("idle_ram_we", {31'd0, ram_we}, 32'd0);
    chk("idle_ram_addr_hold", {22'd0, ram_addr}, 32'd55);
    chk("idle_ram_wdata_hold", {24'd0, ram_wdata}, 32'h56);

    // B reads 55: rvalid_b two edges after the handshake.
    req_b = 1'b1; we_b = 1'b0; addr_b = 10'd55;
    #1;
    chk("rdb_gnt_b", {31'd0, gnt_b}, 32'd1);
    push(1'b1, 8'h56);
    tick();
    req_b = 1'b0;
    chk("rdb_rvalid_e0", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    tick();
    chk("rdb_rvalid_e1", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    tick();
    chk("rdb_rvalid_e2", {30'd0, rvalid_a, rvalid_b}, 32'd1);
    chk("rdb_rdata", {24'd0, rdata}, 32'h56);
    tick();
    chk("rdb_rvalid_e3", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    chk("rdb_rdata_hold", {24'd0, rdata}, 32'h56);

    // Seed 66 with 8'h36, then reset so the next contention is the first.
    req_a = 1'b1; we_a = 1'b1; addr_a = 10'd66; wdata_a = 8'h36;
    tick();
    req_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Contending reads: A (55) first, then B (66).
    req_a = 1'b1; we_a = 1'b0; addr_a = 10'd55;
    req_b = 1'b1; we_b = 1'b0; addr_b = 10'd66;
    #1;
    chk("cont_gnt_a", {30'd0, gnt_a, gnt_b}, 32'd2);
    push(1'b0, 8'h56);
    tick();
    req_a = 1'b0;
    #1;
    chk("cont_gnt_b", {30'd0, gnt_a, gnt_b}, 32'd1);
    push(1'b1, 8'h36);
    tick();
    req_b = 1'b0;
    tick();
    chk("cont_rvalid_a", {30'd0, rvalid_a, rvalid_b}, 32'd2);
    chk("cont_rdata_a", {24'd0, rdata}, 32'h56);
    tick();
    chk("cont_rvalid_b", {30'd0, rvalid_a, rvalid_b}, 32'd1);
    chk("cont_rdata_b", {24'd0, rdata}, 32'h36);
    tick();

    // Both hold requests (writes) for 4 cycles: A,B,A,B.
    req_a = 1'b1; we_a = 1'b1; addr_a = 10'd100; wdata_a = 8'h11;
    req_b = 1'b1; we_b = 1'b1; addr_b = 10'd101; wdata_b = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt", {30'd0, gnt_a, gnt_b}, (i % 2 == 0) ? 32'd2 : 32'd1);
      tick();
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();

    // A writes then reads 66 in consecutive grants, twice with different data.
    req_a = 1'b1; we_a = 1'b1; addr_a = 10'd66; wdata_a = 8'h36;
    #1;
    chk("wr66_gnt_a", {31'd0, gnt_a}, 32'd1);
    tick();
    we_a = 1'b0;
    #1;
    chk("rd66_gnt_a", {31'd0, gnt_a}, 32'd1);
    push(1'b0, 8'h36);
    tick();
    we_a = 1'b1; wdata_a = 8'hA5;
    tick();
    we_a = 1'b0;
    push(1'b0, 8'hA5);
    tick();
    req_a = 1'b0;
    tick(); tick(); tick(); tick();

    // Read by A, reset one cycle later: the read must never return.
    req_a = 1'b1; we_a = 1'b0; addr_a = 10'd55;
    tick();
    req_a = 1'b0;
    tick();
    rst = 1'b1;
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b1; we_b = 1'b1;
    #1;
    chk("mid_rst_gnt", {30'd0, gnt_a, gnt_b}, 32'd0);
    tick();
    chk("mid_rst_rvalid", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    chk("mid_rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("mid_rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("mid_rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    chk("mid_rst_rdata", {24'd0, rdata}, 32'd0);
    tick();
    chk("mid_rst_rvalid2", {30'd0, rvalid_a, rvalid_b}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
    tick();
    req_a = 1'b0; req_b = 1'b0;
    tick(); tick(); tick(); tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameters: AW, default 10, RAM address width; DW, default 8, RAM data width.
REQ-002 SHALL have port clk, input, 1 bit, single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have ports req_a / req_b, input, 1 bit each, requester access request.
REQ-005 SHALL have ports we_a / we_b, input, 1 bit each, 1 = write, 0 = read.
REQ-006 SHALL have ports addr_a / addr_b, input, AW bits each, access address.
REQ-007 SHALL have ports wdata_a / wdata_b, input, DW bits each, write data.
REQ-008 SHALL have ports gnt_a / gnt_b, output, 1 bit each, combinational acceptance of the current request.
REQ-009 SHALL have ports rvalid_a / rvalid_b, output, 1 bit each, read data valid for that requester.
REQ-010 SHALL have port rdata, output, DW bits, read return data, shared by both requesters.
REQ-011 SHALL have ports ram_we (1 bit), ram_addr (AW bits) and ram_wdata (DW bits), outputs, registered command to the single-port RAM write_enable, address and data_in.
REQ-012 SHALL have port ram_rdata, input, DW bits, RAM data_out, registered inside the RAM and one cycle after the sampled address.

Function
REQ-013 SHALL complete an access on a rising edge when req_x=1 and gnt_x=1 (handshake); requester holds we/addr/wdata stable while req_x=1 and gnt_x=0.
REQ-014 SHALL compute gnt combinationally: only req_a -> gnt_a; only req_b -> gnt_b; both -> the requester not granted last; neither -> none; never both high.
REQ-015 SHALL keep last-winner pointer last, updated to the winner on each handshake and held otherwise.
REQ-016 SHALL accept one access per cycle, back-to-back, with no idle cycle between grants.
REQ-017 SHALL run a command FSM with states IDLE, CMD_A and CMD_B, holding the owner of the registered RAM command; handshake by A -> CMD_A, by B -> CMD_B, no handshake -> IDLE.
REQ-018 SHALL, on a handshake, register ram_addr<=addr_x, ram_wdata<=wdata_x and ram_we<=we_x at that edge.
REQ-019 SHALL drive ram_we=0 in IDLE and hold ram_addr and ram_wdata at their last values.
REQ-020 SHALL track reads in a 2-stage tag pipeline (valid plus owner); a read handshaked at edge E gives rvalid_x=1 for exactly one cycle starting at edge E+2.
REQ-021 SHALL drive rdata = ram_rdata whenever either rvalid is 1, and hold the last returned value otherwise.
REQ-022 SHALL never assert rvalid for writes, and never assert rvalid_a and rvalid_b together.
REQ-023 SHALL, on a read after a write to the same address in consecutive grants, return the newly written data (RAM ordering preserved, no bypass).
REQ-024 SHALL let a requester holding req high with both contending alternate A,B,A,B on every cycle.

Reset
REQ-025 SHALL, while rst=1, force: FSM to IDLE, ram_we=0, ram_addr=0, ram_wdata=0, rdata=0, rvalid_a=rvalid_b=0, tag pipeline cleared, last=B (A wins first contention).
REQ-026 SHALL, if rst asserts mid-read, never issue the pending rvalid; gnt_a and gnt_b stay 0 while rst=1.
REQ-027 SHALL resume normal arbitration on the first rising edge after rst deasserts.

Verification
REQ-028 SHALL pass: reset, then A writes 8'h56 to 55 -> gnt_a=1 same cycle, next cycle ram_we=1, ram_addr=55, ram_wdata=8'h56, no rvalid.
REQ-029 SHALL pass: after REQ-028, B reads 55 -> rvalid_b=1 two edges after the handshake, rdata=8'h56, rvalid_a stays 0.
REQ-030 SHALL pass: A and B both request reads (A 55, B 66 holding 8'h36) in the first contention after reset -> gnt_a first, then gnt_b next cycle; rvalid_a with 8'h56, then rvalid_b with 8'h36 on consecutive cycles.
REQ-031 SHALL pass: both hold req high for 4 cycles -> grant order A,B,A,B, exactly one gnt per cycle.
REQ-032 SHALL pass: A writes 8'h36 to 66, then A reads 66 immediately next cycle -> rvalid_a with rdata=8'h36.
REQ-033 SHALL pass: rst pulsed one cycle after a read handshake -> no rvalid; all outputs reset; the next contention is won by A.
